// File: rtl/gpr_pkg.sv
// Purpose: shared widths, iss_use bit indices and operand-set type for the GPR operand-fetch slice.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: GPR_ADR_W/GPR_DAT_W/GPR_NUM, USE_RA/USE_RB/USE_RC, gpr_adr_t, gpr_dat_t, opset_t, adr_hit().
package gpr_pkg;

  localparam int GPR_ADR_W = 5;
  localparam int GPR_DAT_W = 32;
  localparam int GPR_NUM   = 32;

  // Bit positions inside iss_use
  localparam int ISS_USE_W = 3;
  localparam int USE_RA    = 0;
  localparam int USE_RB    = 1;
  localparam int USE_RC    = 2;

  typedef logic [GPR_ADR_W-1:0] gpr_adr_t;
  typedef logic [GPR_DAT_W-1:0] gpr_dat_t;

  // One operand set handed to execute
  typedef struct packed {
    gpr_dat_t a;
    gpr_dat_t b;
    gpr_dat_t c;
    gpr_adr_t rt;
    logic     rt_val;
  } opset_t;

  // True when a qualified address matches another address
  function automatic logic adr_hit(input logic vld, input gpr_adr_t x, input gpr_adr_t y);
    return vld && (x == y);
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Purpose: GPR busy-bit scoreboard; set on issue with a destination, clear on writeback, set wins on a tie.
// Latency: set/clear visible one cycle after the request edge; lookups are combinational from current state.
// Backpressure: none; set and clear are always accepted.
// Ports: clk, rst_n; set_en/set_adr; clr_en/clr_adr; lk_adr_0..2 -> lk_busy_0..2; lk_adr_rt -> lk_busy_rt.
module gpr_scoreboard
  import gpr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [GPR_ADR_W-1:0] set_adr,
  input  logic                 clr_en,
  input  logic [GPR_ADR_W-1:0] clr_adr,
  input  logic [GPR_ADR_W-1:0] lk_adr_0,
  input  logic [GPR_ADR_W-1:0] lk_adr_1,
  input  logic [GPR_ADR_W-1:0] lk_adr_2,
  input  logic [GPR_ADR_W-1:0] lk_adr_rt,
  output logic                 lk_busy_0,
  output logic                 lk_busy_1,
  output logic                 lk_busy_2,
  output logic                 lk_busy_rt
);

  localparam logic [GPR_NUM-1:0] ONE_HOT_0 = {{(GPR_NUM-1){1'b0}}, 1'b1};

  logic [GPR_NUM-1:0] busy;
  logic [GPR_NUM-1:0] set_vec;
  logic [GPR_NUM-1:0] clr_vec;

  assign set_vec = set_en ? (ONE_HOT_0 << set_adr) : '0;
  assign clr_vec = clr_en ? (ONE_HOT_0 << clr_adr) : '0;

  // Clear is applied first and set ORed afterwards, so a same-register
  // set and clear in one cycle leaves the bit set: the new producer owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

  assign lk_busy_0  = busy[lk_adr_0];
  assign lk_busy_1  = busy[lk_adr_1];
  assign lk_busy_2  = busy[lk_adr_2];
  assign lk_busy_rt = busy[lk_adr_rt];

endmodule

// File: rtl/gpr_opfetch.sv
// Purpose: operand fetch stage; reads up to three GPR sources, tracks RAW/WAW hazards, registers one operand set.
// Latency: 1 cycle from accepted issue to op_val.
// Backpressure: iss_rdy drops on a hazard or when the held operand set is not consumed; writeback is never stalled.
// Ports: clk, rst_n; iss_val/iss_rdy, iss_ra/rb/rc, iss_use, iss_rt, iss_rt_val; op_val/op_rdy, op_a/b/c, op_rt,
//        op_rt_val; wb_val/wb_adr/wb_dat; rd_adr_0..2/rd_dat_0..2 (GPR read); wr_en_0/wr_adr_0/wr_dat_0 (GPR write).
// Config: define GPR_OPF_BYPASS_EN to forward same-cycle writeback data into the operands instead of stalling.
module gpr_opfetch
  import gpr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  // issue side
  input  logic                 iss_val,
  output logic                 iss_rdy,
  input  logic [GPR_ADR_W-1:0] iss_ra,
  input  logic [GPR_ADR_W-1:0] iss_rb,
  input  logic [GPR_ADR_W-1:0] iss_rc,
  input  logic [ISS_USE_W-1:0] iss_use,
  input  logic [GPR_ADR_W-1:0] iss_rt,
  input  logic                 iss_rt_val,
  // execute side
  output logic                 op_val,
  input  logic                 op_rdy,
  output logic [GPR_DAT_W-1:0] op_a,
  output logic [GPR_DAT_W-1:0] op_b,
  output logic [GPR_DAT_W-1:0] op_c,
  output logic [GPR_ADR_W-1:0] op_rt,
  output logic                 op_rt_val,
  // writeback
  input  logic                 wb_val,
  input  logic [GPR_ADR_W-1:0] wb_adr,
  input  logic [GPR_DAT_W-1:0] wb_dat,
  // GPR array ports
  output logic [GPR_ADR_W-1:0] rd_adr_0,
  output logic [GPR_ADR_W-1:0] rd_adr_1,
  output logic [GPR_ADR_W-1:0] rd_adr_2,
  input  logic [GPR_DAT_W-1:0] rd_dat_0,
  input  logic [GPR_DAT_W-1:0] rd_dat_1,
  input  logic [GPR_DAT_W-1:0] rd_dat_2,
  output logic                 wr_en_0,
  output logic [GPR_ADR_W-1:0] wr_adr_0,
  output logic [GPR_DAT_W-1:0] wr_dat_0
);

  // GPR ports are pure wiring; they keep working through reset.
  assign rd_adr_0 = iss_ra;
  assign rd_adr_1 = iss_rb;
  assign rd_adr_2 = iss_rc;
  assign wr_en_0  = wb_val;
  assign wr_adr_0 = wb_adr;
  assign wr_dat_0 = wb_dat;

  logic                                  iss_xfer;
  logic                                  busy_0, busy_1, busy_2, busy_rt;
  logic [ISS_USE_W-1:0][GPR_ADR_W-1:0]   src_adr;
  logic [ISS_USE_W-1:0][GPR_DAT_W-1:0]   src_rd;
  logic [ISS_USE_W-1:0]                  src_busy;
  logic [ISS_USE_W-1:0]                  src_hit;
  logic [ISS_USE_W-1:0]                  src_haz;
  logic [ISS_USE_W-1:0][GPR_DAT_W-1:0]   src_dat;
  logic                                  raw_haz;
  logic                                  waw_haz;
  opset_t                                op_nxt;
  opset_t                                op_q;
  logic                                  op_val_q;

  assign src_adr  = {iss_rc, iss_rb, iss_ra};
  assign src_rd   = {rd_dat_2, rd_dat_1, rd_dat_0};
  assign src_busy = {busy_2, busy_1, busy_0};

  assign iss_xfer = iss_val & iss_rdy;

  gpr_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (iss_xfer & iss_rt_val),
    .set_adr    (iss_rt),
    .clr_en     (wb_val),
    .clr_adr    (wb_adr),
    .lk_adr_0   (iss_ra),
    .lk_adr_1   (iss_rb),
    .lk_adr_2   (iss_rc),
    .lk_adr_rt  (iss_rt),
    .lk_busy_0  (busy_0),
    .lk_busy_1  (busy_1),
    .lk_busy_2  (busy_2),
    .lk_busy_rt (busy_rt)
  );

  // Per-source hazard and operand selection. Without forwarding, a source
  // being written this cycle still reads stale data from the array, so it
  // must wait one more cycle even if the scoreboard bit was never set.
  always_comb begin
    src_hit = '0;
    src_haz = '0;
    src_dat = '0;
    for (int i = 0; i < ISS_USE_W; i++) begin
      src_hit[i] = adr_hit(wb_val, wb_adr, src_adr[i]);
`ifdef GPR_OPF_BYPASS_EN
      src_haz[i] = src_busy[i] & ~src_hit[i];
      src_dat[i] = src_hit[i] ? wb_dat : src_rd[i];
`else
      src_haz[i] = src_busy[i] | src_hit[i];
      src_dat[i] = src_rd[i];
`endif
      // Unused sources never stall and always present zero downstream
      if (!iss_use[i]) begin
        src_haz[i] = 1'b0;
        src_dat[i] = '0;
      end
    end
  end

  assign raw_haz = |src_haz;
  // A same-cycle writeback to the destination retires the older producer,
  // so the new write intent can be recorded right away.
  assign waw_haz = iss_rt_val & busy_rt & ~adr_hit(wb_val, wb_adr, iss_rt);

  // rst_n gates ready so nothing is offered to the issuer during reset.
  assign iss_rdy = rst_n & (~op_val_q | op_rdy) & ~raw_haz & ~waw_haz;

  always_comb begin
    op_nxt        = '0;
    op_nxt.a      = src_dat[USE_RA];
    op_nxt.b      = src_dat[USE_RB];
    op_nxt.c      = src_dat[USE_RC];
    op_nxt.rt     = iss_rt;
    op_nxt.rt_val = iss_rt_val;
  end

  // Operand register: loads on transfer, otherwise holds; the held set is
  // only released (op_val dropped) when execute takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_val_q <= 1'b0;
      op_q     <= '0;
    end else if (iss_xfer) begin
      op_val_q <= 1'b1;
      op_q     <= op_nxt;
    end else if (op_rdy) begin
      op_val_q <= 1'b0;
    end
  end

  assign op_val    = op_val_q;
  assign op_a      = op_q.a;
  assign op_b      = op_q.b;
  assign op_c      = op_q.c;
  assign op_rt     = op_q.rt;
  assign op_rt_val = op_q.rt_val;

endmodule

// File: tb/tb_gpr_opfetch.sv
// Purpose: self-checking bench for gpr_opfetch; directed scenarios plus randomized traffic against a reference model.
// Latency: model expects operands one cycle after an accepted issue.
// Backpressure: random op_rdy stalls and writeback-driven hazards are exercised.
module tb_gpr_opfetch;
  import gpr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        iss_val, iss_rdy;
  logic [4:0]  iss_ra, iss_rb, iss_rc, iss_rt;
  logic [2:0]  iss_use;
  logic        iss_rt_val;
  logic        op_val, op_rdy;
  logic [31:0] op_a, op_b, op_c;
  logic [4:0]  op_rt;
  logic        op_rt_val;
  logic        wb_val;
  logic [4:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [4:0]  rd_adr_0, rd_adr_1, rd_adr_2;
  logic [31:0] rd_dat_0, rd_dat_1, rd_dat_2;
  logic        wr_en_0;
  logic [4:0]  wr_adr_0;
  logic [31:0] wr_dat_0;

  // GPR array lives in the bench: combinational read, written one step after the edge
  logic [31:0] gpr [32];
  assign rd_dat_0 = gpr[rd_adr_0];
  assign rd_dat_1 = gpr[rd_adr_1];
  assign rd_dat_2 = gpr[rd_adr_2];

  gpr_opfetch dut (
    .clk(clk), .rst_n(rst_n),
    .iss_val(iss_val), .iss_rdy(iss_rdy),
    .iss_ra(iss_ra), .iss_rb(iss_rb), .iss_rc(iss_rc),
    .iss_use(iss_use), .iss_rt(iss_rt), .iss_rt_val(iss_rt_val),
    .op_val(op_val), .op_rdy(op_rdy),
    .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .op_rt(op_rt), .op_rt_val(op_rt_val),
    .wb_val(wb_val), .wb_adr(wb_adr), .wb_dat(wb_dat),
    .rd_adr_0(rd_adr_0), .rd_adr_1(rd_adr_1), .rd_adr_2(rd_adr_2),
    .rd_dat_0(rd_dat_0), .rd_dat_1(rd_dat_1), .rd_dat_2(rd_dat_2),
    .wr_en_0(wr_en_0), .wr_adr_0(wr_adr_0), .wr_dat_0(wr_dat_0)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [31:0] m_busy;
  bit        m_opv;
  bit [31:0] m_a, m_b, m_c;
  bit [4:0]  m_rt;
  bit        m_rtv;
  bit        p_rdy;
  bit [31:0] p_a, p_b, p_c;
  bit        seen_rdy;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_opv = 0; m_a = 0; m_b = 0; m_c = 0; m_rt = 0; m_rtv = 0;
  endtask

  // Source rule: value the operand should take and whether the source blocks issue
  function automatic bit [31:0] src_val(input bit used, input bit [4:0] s, output bit haz);
    bit hit;
    hit = (wb_val === 1'b1) && (wb_adr == s);
    haz = 0;
    if (!used) return 32'h0;
`ifdef GPR_OPF_BYPASS_EN
    if (hit) return wb_dat;
    haz = m_busy[s];
    return gpr[s];
`else
    haz = m_busy[s] || hit;
    return gpr[s];
`endif
  endfunction

  // One clock: inputs were driven at the preceding negedge
  task automatic cyc();
    bit ha, hb, hc, waw, xfer;
    #1;
    p_a = src_val(iss_use[0], iss_ra, ha);
    p_b = src_val(iss_use[1], iss_rb, hb);
    p_c = src_val(iss_use[2], iss_rc, hc);
    waw = iss_rt_val && m_busy[iss_rt] && !(wb_val && wb_adr == iss_rt);
    p_rdy = rst_n && (!m_opv || op_rdy) && !ha && !hb && !hc && !waw;
    seen_rdy = iss_rdy;
    chk("iss_rdy", iss_rdy, p_rdy);
    chk("op_val", op_val, m_opv);
    chk("op_a", op_a, m_a);
    chk("op_b", op_b, m_b);
    chk("op_c", op_c, m_c);
    chk("op_rt", {op_rt_val, op_rt}, {m_rtv, m_rt});
    chk("rd_adr", {rd_adr_2, rd_adr_1, rd_adr_0}, {iss_rc, iss_rb, iss_ra});
    chk("wr_port", {wr_en_0, wr_adr_0}, {wb_val, wb_adr});
    chk("wr_dat", wr_dat_0, wb_dat);
    @(posedge clk);
    #1;
    if (rst_n) begin
      xfer = iss_val && p_rdy;
      if (xfer) begin
        m_opv = 1; m_a = p_a; m_b = p_b; m_c = p_c; m_rt = iss_rt; m_rtv = iss_rt_val;
      end else if (op_rdy) begin
        m_opv = 0;
      end
      if (wb_val) m_busy[wb_adr] = 0;
      if (xfer && iss_rt_val) m_busy[iss_rt] = 1;
    end
    if (wb_val) gpr[wb_adr] = wb_dat;
    @(negedge clk);
  endtask

  task automatic idle();
    iss_val = 0; iss_use = 0; iss_rt_val = 0; iss_ra = 0; iss_rb = 0; iss_rc = 0; iss_rt = 0;
    wb_val = 0; wb_adr = 0; wb_dat = 0; op_rdy = 1;
  endtask

  task automatic iss(input bit [4:0] ra, input bit [4:0] rb, input bit [4:0] rc,
                     input bit [2:0] use_m, input bit [4:0] rt, input bit rtv);
    iss_val = 1; iss_ra = ra; iss_rb = rb; iss_rc = rc; iss_use = use_m; iss_rt = rt; iss_rt_val = rtv;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gpr[i] = $urandom;
    gpr[3] = 32'h11;
    gpr[4] = 32'h22;
    idle();
    #2 rst_n = 0;
    model_reset();
    @(negedge clk);
    iss(1, 2, 3, 3'b111, 0, 0);  // issue offered during reset must be ignored
    cyc();
    chk("rst_rdy", seen_rdy, 0);
    cyc();
    chk("rst_opv", op_val, 0);
    rst_n = 1;
    idle();
    cyc();
    chk("rdy_after_rst", seen_rdy, 1);

    // Basic fetch of two sources
    iss(3, 4, 0, 3'b011, 0, 0);
    cyc();
    idle();
    chk("r033_opv", op_val, 1);
    chk("r033_opa", op_a, 32'h11);
    chk("r033_opb", op_b, 32'h22);
    chk("r033_opc", op_c, 32'h0);
    cyc();

    // RAW on r5 released by writeback
    iss(0, 0, 0, 3'b000, 5, 1);
    cyc();
    iss(5, 0, 0, 3'b001, 0, 0);
    cyc();
    chk("r034_stall0", seen_rdy, 0);
    cyc();
    chk("r034_stall1", seen_rdy, 0);
    wb_val = 1; wb_adr = 5; wb_dat = 32'hABCD;
    cyc();
    wb_val = 0;
`ifdef GPR_OPF_BYPASS_EN
    chk("r034_byp_rdy", seen_rdy, 1);
`else
    chk("r034_wb_stall", seen_rdy, 0);
    cyc();
    chk("r034_late_rdy", seen_rdy, 1);
`endif
    iss_val = 0;
    chk("r034_opa", op_a, 32'hABCD);
    chk("r034_opv", op_val, 1);
    cyc();

    // Execute backpressure holds the operand set
    iss(1, 2, 0, 3'b011, 0, 0);
    cyc();
    iss(6, 0, 0, 3'b001, 0, 0);
    op_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("r035_bp_rdy", seen_rdy, 0);
      chk("r035_hold_a", op_a, gpr[1]);
      chk("r035_hold_b", op_b, gpr[2]);
    end
    op_rdy = 1;
    cyc();
    chk("r035_release_rdy", seen_rdy, 1);
    idle();
    chk("r035_new_a", op_a, gpr[6]);
    chk("r035_new_v", op_val, 1);
    cyc();

    // Set beats clear on r7
    iss(0, 0, 0, 3'b000, 7, 1);
    cyc();
    idle();
    cyc();
    iss(0, 0, 0, 3'b000, 7, 1);
    wb_val = 1; wb_adr = 7; wb_dat = 32'h77;
    cyc();
    chk("r036_waw_wb_rdy", seen_rdy, 1);
    wb_val = 0;
    iss(7, 0, 0, 3'b001, 0, 0);
    cyc();
    chk("r036_still_busy", seen_rdy, 0);
    wb_val = 1; wb_adr = 7; wb_dat = 32'h7777;
    cyc();
    idle();
    cyc();

    // WAW on r2 released by same-cycle writeback
    iss(0, 0, 0, 3'b000, 2, 1);
    cyc();
    iss(0, 0, 0, 3'b000, 2, 1);
    cyc();
    chk("r038_waw", seen_rdy, 0);
    wb_val = 1; wb_adr = 2; wb_dat = 32'h2222;
    cyc();
    chk("r038_wb_release", seen_rdy, 1);
    idle();
    cyc();

    // Asynchronous reset in the middle of a stall
    iss(0, 0, 0, 3'b000, 9, 1);
    cyc();
    iss(9, 0, 0, 3'b001, 0, 0);
    cyc();
    chk("r037_stall", seen_rdy, 0);
    #3 rst_n = 0;
    #1;
    chk("r037_async_opv", op_val, 0);
    chk("r037_async_rdy", iss_rdy, 0);
    chk("r037_async_rt", {op_rt_val, op_rt}, 0);
    model_reset();
    @(negedge clk);
    cyc();
    rst_n = 1;
    cyc();
    chk("r037_accept", seen_rdy, 1);
    idle();
    chk("r037_opa", op_a, gpr[9]);
    cyc();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      iss_val    = $urandom_range(0, 1);
      iss_ra     = 5'($urandom_range(0, 7));
      iss_rb     = 5'($urandom_range(0, 7));
      iss_rc     = 5'($urandom_range(0, 7));
      iss_use    = 3'($urandom);
      iss_rt     = 5'($urandom_range(0, 7));
      iss_rt_val = $urandom_range(0, 1);
      op_rdy     = ($urandom_range(0, 3) != 0);
      wb_val     = ($urandom_range(0, 2) == 0);
      wb_adr     = 5'($urandom_range(0, 7));
      wb_dat     = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 0;
        model_reset();
      end else begin
        rst_n = 1;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/gpr_opfetch.md
GPR_OPFETCH -- requirements
Module: gpr_opfetch

Interface
REQ-001 The block SHALL have no parameters; widths SHALL come from gpr_pkg (GPR_ADR_W=5, GPR_DAT_W=32, GPR_NUM=32).
REQ-002 clk  in  1  single clock; all state on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 iss_val in 1, iss_rdy out 1: issue handshake; transfer when both are high.
REQ-005 iss_ra, iss_rb, iss_rc  in  5 each  source GPR addresses.
REQ-006 iss_use  in  3  per-source use mask; bit0=ra, bit1=rb, bit2=rc.
REQ-007 iss_rt in 5, iss_rt_val in 1: destination GPR and its write-intent flag.
REQ-008 op_val out 1, op_rdy in 1: operand handshake to execute.
REQ-009 op_a, op_b, op_c out 32 each: operand values; op_rt out 5 and op_rt_val out 1: issue fields passed through.
REQ-010 wb_val in 1, wb_adr in 5, wb_dat in 32: writeback request; always accepted, never stalled.
REQ-011 rd_adr_0, rd_adr_1, rd_adr_2  out  5 each  GPR read addresses; rd_dat_0..2  in  32 each  GPR read data, combinational from the address.
REQ-012 wr_en_0 out 1, wr_adr_0 out 5, wr_dat_0 out 32: GPR write port; the GPR writes on posedge clk.

Function
REQ-013 rd_adr_0/1/2 SHALL equal iss_ra/rb/rc combinationally.
REQ-014 wr_en_0, wr_adr_0 and wr_dat_0 SHALL equal wb_val, wb_adr and wb_dat combinationally.
REQ-015 The scoreboard SHALL hold 32 busy bits; an accepted issue with iss_rt_val=1 SHALL set busy[iss_rt]; wb_val=1 SHALL clear busy[wb_adr].
REQ-016 When set and clear target the same register in the same cycle, set SHALL win.
REQ-017 wb_val to a non-busy register SHALL write the GPR and leave the scoreboard unchanged.
REQ-018 A RAW hazard SHALL exist when, for any source with its iss_use bit set, busy[src]=1 or (wb_val=1 and wb_adr=src), except where REQ-029 applies.
REQ-019 A WAW hazard SHALL exist when iss_rt_val=1, busy[iss_rt]=1, and there is no same-cycle wb_val to iss_rt.
REQ-020 iss_rdy SHALL equal (!op_val | op_rdy) & !RAW & !WAW; iss_rdy SHALL NOT depend on iss_val.
REQ-021 On transfer, the operand register SHALL load rd_dat_x, or the bypass value under REQ-029, on the next edge; issue-to-op_val latency SHALL be 1 cycle.
REQ-022 Unused sources SHALL load 0 into their op_x.
REQ-023 While op_val=1 and op_rdy=0, all op_* outputs SHALL hold stable.
REQ-024 op_val SHALL clear on op_rdy=1 unless a new issue transfers in the same cycle; back-to-back issues SHALL give one operand set per cycle.

Reset
REQ-025 When rst_n=0: op_val=0, op_a/b/c=0, op_rt=0, op_rt_val=0, and all busy bits=0, applied immediately and independent of clk.
REQ-026 iss_rdy SHALL be 0 while rst_n=0, and 1 in the first cycle after deassertion.
REQ-027 An in-flight operand set at reset SHALL be discarded, with no op_val pulse after reset.
REQ-028 Combinational pass-through (REQ-013, REQ-014) SHALL be unaffected by reset.

Configuration
REQ-029 With GPR_OPF_BYPASS_EN defined, a source matching a same-cycle wb_adr with wb_val=1 SHALL NOT be a hazard and SHALL load wb_dat; if the match is to a busy register, that register SHALL be treated as cleared for that source.
REQ-030 With GPR_OPF_BYPASS_EN undefined, REQ-018 SHALL apply unmodified, so the issue stalls at least until the cycle after the writeback.

Structure
REQ-031 gpr_pkg SHALL hold GPR_ADR_W, GPR_DAT_W, GPR_NUM and the iss_use bit-index constants.
REQ-032 The busy-bit array and its set/clear priority SHALL be a sub-module, gpr_scoreboard, with set, clear and a per-source busy lookup.

Verification
REQ-033 Reset then issue ra=3 and rb=4 (use=011), with GPR[3]=0x11 and GPR[4]=0x22 -> next cycle op_val=1, op_a=0x11, op_b=0x22, op_c=0.
REQ-034 Issue rt=5 (rt_val=1), then issue ra=5 -> iss_rdy=0 until wb_val with wb_adr=5 and wb_dat=0xABCD. With the macro: op_a=0xABCD in the cycle after wb. Without it: op_a=0xABCD one cycle later.
REQ-035 Hold op_rdy=0 for 3 cycles with op_val=1 -> op_* stable, iss_rdy=0; op_rdy=1 with a pending issue -> a new set appears next cycle.
REQ-036 Same-cycle issue with rt=7 and wb_adr=7 while busy[7]=1 -> busy[7] remains 1; a later issue with ra=7 stalls.
REQ-037 Assert rst_n=0 mid-stall with busy[9]=1 -> op_val=0 immediately, and after release an issue with ra=9 is accepted at once.
REQ-038 Issue rt=2 while busy[2]=1 and no wb -> WAW stall; wb_adr=2 -> issue accepted in the same cycle.
